// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader for the instruction memory. A byte stream
//   arriving on a valid/ready handshake carries a 16-bit big-endian word
//   count followed by that many 32-bit big-endian instruction words. Each
//   complete word is written to the instruction memory at word addresses
//   0..N-1, and the CPU is held in reset until the load has finished.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle load request (honoured in IDLE, DONE and ERR)
//   in_valid   byte available on in_data
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle (HDR0, HDR1, DATA)
//   im_we      instruction-memory write strobe, one cycle per word
//   im_waddr   instruction-memory word address
//   im_wdata   instruction word, first stream byte in bits [31:24]
//   busy       load in progress (HDR0, HDR1, DATA)
//   done       load finished successfully
//   err        header count larger than the memory depth
//   cpu_rst_n  active-low CPU reset, released one cycle after done rises
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        DONE,
        ERR
    } state_t;

    // Memory depth as a 17-bit value so a 16-bit count can be compared
    // against it without overflow for any legal ADDR_W.
    localparam logic [16:0]     DEPTH    = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0] WCNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         asm_q, asm_d;
    logic                in_ready_q, in_ready_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_waddr_q, im_waddr_d;
    logic [31:0]         im_wdata_q, im_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                accept;
    logic [15:0]         hdr_count;

    // Next-state and datapath logic. in_ready_q is a pure function of the
    // current state, so a transfer is simply in_valid && in_ready_q.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        im_we_d    = 1'b0;
        im_waddr_d = im_waddr_q;
        im_wdata_d = im_wdata_q;
        accept     = in_valid && in_ready_q;
        hdr_count  = {count_q[15:8], in_data};

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = HDR0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                end
            end
            HDR0: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    state_d       = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    if (hdr_count == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, hdr_count} > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    asm_d      = {asm_q[15:0], in_data};
                    // Fourth byte completes the word: issue the write and
                    // finish on this same edge if it was the last word.
                    if (byte_cnt_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = {asm_q, in_data};
                        im_waddr_d = word_cnt_q[ADDR_W-1:0];
                        word_cnt_d = word_cnt_q + WCNT_ONE;
                        if (16'(word_cnt_d) == count_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA);
        busy_d      = in_ready_d;
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
        // Released only once DONE has been held for a full cycle, so the
        // CPU comes out of reset after the last write has landed.
        cpu_rst_n_d = done_q && (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            in_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            im_waddr_q  <= '0;
            im_wdata_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            in_ready_q  <= in_ready_d;
            im_we_q     <= im_we_d;
            im_waddr_q  <= im_waddr_d;
            im_wdata_q  <= im_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign im_we     = im_we_q;
    assign im_waddr  = im_waddr_q;
    assign im_wdata  = im_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory. It accepts a byte stream on a valid/ready handshake and parses a 16-bit big-endian word count followed by that many 32-bit big-endian instruction words. It issues one word write per instruction to the instruction memory's write port, at word addresses 0..N-1. It holds the CPU in reset until the load completes.

## Interface
- ADDR_W, default 10: instruction memory word-address width; depth = 2**ADDR_W words (1024). Legal range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled in IDLE, DONE and ERR only.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_waddr  out  ADDR_W  word address (byte address / 4).
- im_wdata  out  32  instruction word; first stream byte maps to bits [31:24].
- busy  out  1  high in HDR0, HDR1 and DATA.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- cpu_rst_n  out  1  active-low CPU reset; high only in DONE, delayed as described under Timing.

## Operation
- States: IDLE, HDR0, HDR1, DATA, DONE, ERR. Reset enters IDLE.
- Reset values: in_ready=0, im_we=0, im_waddr=0, im_wdata=0, busy=0, done=0, err=0, cpu_rst_n=0. Byte counter, word counter and count register are all 0.
- IDLE/DONE/ERR with start=1 -> HDR0. Word counter and byte counter clear.
- HDR0: accept byte -> count[15:8], then go to HDR1.
- HDR1: accept byte -> count[7:0], then branch on count:
  - count==0 -> DONE. No writes.
  - count > 2**ADDR_W -> ERR.
  - otherwise -> DATA.
- DATA: a 2-bit byte counter shifts bytes into a 32-bit assembly register, MSB first.
  - On acceptance of the 4th byte, register im_we=1, im_wdata=assembled word and im_waddr=word counter, then increment the word counter.
  - When the word counter reaches count, go to DONE on the same edge as the final write.
- in_ready = 1 exactly in HDR0, HDR1 and DATA. It is a registered, state-decoded signal and does not depend on in_valid.
- in_valid is ignored outside HDR0, HDR1 and DATA.
- start is ignored while busy.
- ERR: in_ready=0 and cpu_rst_n=0. The state is held until start or reset.
- The word counter is ADDR_W+1 bits wide, so the full-depth load (count = 2**ADDR_W) terminates correctly. im_waddr takes the low ADDR_W bits of the counter; the last address is 2**ADDR_W-1.
- The loader never erases memory. Contents from an aborted load are left as written.

## Timing
- Byte accepted at edge k is visible in internal state after edge k.
- 4th byte of word j accepted at edge k: im_we=1 with im_waddr=j for exactly the cycle after edge k. Otherwise im_we=0.
- Back-to-back bytes give at most one write per 4 cycles. Gaps in in_valid stall progress with no loss or duplication.
- On the edge of the final write, state goes to DONE: done=1 and busy=0 in the same cycle as the last im_we.
- cpu_rst_n rises one cycle after done rises, so the CPU leaves reset only after the last write has completed.
- start in DONE: cpu_rst_n=0 and done=0 from the next cycle.
- rst_n low at any time: all outputs go to their reset values immediately (asynchronous), and a partial word is discarded.

## Test plan
- Load count=8 (bytes 00 08) followed by the 8 words 8C400000, 8C410001, 00201001, 00011809, 0043200E, 10020001, 00011809, 08000000 -> 8 im_we pulses at addresses 0..7 with matching data; done=1 with the last write; cpu_rst_n=1 one cycle later.
- Same stream with in_valid toggled pseudo-randomly, including holds of 5+ cycles -> identical write sequence; in_ready stays 1 throughout DATA.
- Header 00 00 -> DONE two byte-transfers after start, with no im_we. Header 04 01 with ADDR_W=10 -> err=1, in_ready=0, cpu_rst_n=0 and no writes. Header 04 00 -> 1024 writes, last to address 1023, then done.
- Assert rst_n low after 2.5 words -> all outputs reset asynchronously. Then start and load 1 word (00 01 12345678) -> a single write to address 0 with 12345678.
- Pulse start mid-DATA -> ignored, and the load completes normally. Pulse start in DONE -> cpu_rst_n=0 next cycle, and a new load writes from address 0.
